// File: rtl/oser8_tx_sched.sv
// Link sequencer in front of an OSER8: serializer reset, training burst, then
// round-robin packet arbitration of two requesters with idle fill.
module oser8_tx_sched #(
    parameter int         RST_CYCLES  = 8,
    parameter int         TRAIN_WORDS = 16,
    parameter logic [7:0] TRAIN_PAT   = 8'h6A,
    parameter logic [7:0] IDLE_WORD   = 8'h00,
    parameter logic [3:0] TX_OFF      = 4'hF
) (
    input  logic       PCLK,
    input  logic       RESET,
    input  logic       RETRAIN,
    input  logic       REQ0_VALID,
    input  logic [7:0] REQ0_DATA,
    input  logic       REQ0_LAST,
    input  logic       REQ1_VALID,
    input  logic [7:0] REQ1_DATA,
    input  logic       REQ1_LAST,
    output logic       REQ0_READY,
    output logic       REQ1_READY,
    output logic       SER_RESET,
    output logic [7:0] SER_D,
    output logic [3:0] SER_TX,
    output logic       LINK_UP,
    output logic [1:0] GRANT
);

    localparam int MAX_COUNT = (RST_CYCLES > TRAIN_WORDS) ? RST_CYCLES : TRAIN_WORDS;
    localparam int CW        = $clog2(MAX_COUNT + 1);
    localparam logic [CW-1:0] RST_LOAD   = CW'(RST_CYCLES);
    localparam logic [CW-1:0] TRAIN_LOAD = CW'(TRAIN_WORDS - 1);

    typedef enum logic [1:0] {
        ST_RST,
        ST_TRAIN,
        ST_IDLE,
        ST_DATA
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ptr_q, ptr_d;
    logic          owner_q, owner_d;
    logic          pending_q, pending_d;
    logic [1:0]    grant_q, grant_d;
    logic          serReset_q, serReset_d;
    logic [7:0]    serD_q, serD_d;
    logic [3:0]    serTx_q, serTx_d;
    logic          linkUp_q, linkUp_d;

    logic          pick1;
    logic          srcSel;
    logic          ready0, ready1;
    logic          accept;
    logic [7:0]    selData;
    logic          selLast;

    // Round-robin pick: the pointer names the favoured requester.
    assign pick1   = ptr_q ? (REQ1_VALID || !REQ0_VALID) : (!REQ0_VALID && REQ1_VALID);
    assign srcSel  = (state_q == ST_DATA) ? owner_q : pick1;
    assign selData = srcSel ? REQ1_DATA : REQ0_DATA;
    assign selLast = srcSel ? REQ1_LAST : REQ0_LAST;
    assign accept  = (REQ0_VALID && ready0) || (REQ1_VALID && ready1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        pending_d = pending_q;
        grant_d   = grant_q;
        ready0    = 1'b0;
        ready1    = 1'b0;

        case (state_q)
            ST_RST: begin
                if (cnt_q == '0) begin
                    state_d = ST_TRAIN;
                    cnt_d   = TRAIN_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_TRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_IDLE: begin
                // A retrain (fresh or deferred from a packet) wins over any new grant.
                if (RETRAIN || pending_q) begin
                    state_d   = ST_TRAIN;
                    cnt_d     = TRAIN_LOAD;
                    pending_d = 1'b0;
                end else if (REQ0_VALID || REQ1_VALID) begin
                    ready0 = !pick1;
                    ready1 = pick1;
                    if (!selLast) begin
                        state_d = ST_DATA;
                        owner_d = pick1;
                        grant_d = pick1 ? 2'b10 : 2'b01;
                    end else begin
                        ptr_d = !pick1;
                    end
                end
            end
            ST_DATA: begin
                ready0    = !owner_q && REQ0_VALID;
                ready1    = owner_q && REQ1_VALID;
                pending_d = pending_q || RETRAIN;
                if (accept && selLast) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    ptr_d   = !owner_q;
                end
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = RST_LOAD;
            end
        endcase

        serReset_d = (state_d == ST_RST);
        serTx_d    = (state_d == ST_RST) ? TX_OFF : 4'h0;
        linkUp_d   = (state_d == ST_IDLE) || (state_d == ST_DATA);
        if (accept) begin
            serD_d = selData;
        end else if (state_d == ST_TRAIN) begin
            serD_d = TRAIN_PAT;
        end else begin
            serD_d = IDLE_WORD;
        end
    end

    // Reset aborts any packet and drops a deferred retrain.
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            state_q    <= ST_RST;
            cnt_q      <= RST_LOAD;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            pending_q  <= 1'b0;
            grant_q    <= 2'b00;
            serReset_q <= 1'b1;
            serD_q     <= IDLE_WORD;
            serTx_q    <= TX_OFF;
            linkUp_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            pending_q  <= pending_d;
            grant_q    <= grant_d;
            serReset_q <= serReset_d;
            serD_q     <= serD_d;
            serTx_q    <= serTx_d;
            linkUp_q   <= linkUp_d;
        end
    end

    assign REQ0_READY = ready0;
    assign REQ1_READY = ready1;
    assign SER_RESET  = serReset_q;
    assign SER_D      = serD_q;
    assign SER_TX     = serTx_q;
    assign LINK_UP    = linkUp_q;
    assign GRANT      = grant_q;

endmodule

// File: doc/oser8_tx_sched.md
# oser8_tx_sched

Word scheduler and link sequencer that drives one OSER8 8:1 serializer from the PCLK domain. After reset it holds the serializer in reset, then emits a training pattern. It then arbitrates two packet requesters onto the serializer's parallel inputs with round-robin fairness and packet locking, and fills gaps with an idle word. It sits directly in front of an OSER8 instance; SER_RESET, SER_D and SER_TX connect to its RESET, D0..D7 and TX0..TX3.

## Interface
- RST_CYCLES, 8: PCLK cycles SER_RESET is held high after RESET is released; must be ≥ 1.
- TRAIN_WORDS, 16: number of training words sent after the serializer reset; must be ≥ 1.
- TRAIN_PAT, 8'h6A: training word, sent on SER_D with D0 = bit 0.
- IDLE_WORD, 8'h00: fill word, sent when no payload word is accepted.
- TX_OFF, 4'hF: SER_TX value while the link is in reset. 1 means output disabled.

Ports:
- PCLK  in  1  parallel clock. Same clock as the OSER8 PCLK.
- RESET  in  1  synchronous, active-high reset, sampled on rising PCLK.
- RETRAIN  in  1  request to re-send the training sequence. Level-sensitive; must be held high for at least one cycle.
- REQ0_VALID / REQ1_VALID  in  1  requester has a word. Must not depend on READY.
- REQ0_DATA / REQ1_DATA  in  8  payload word.
- REQ0_LAST / REQ1_LAST  in  1  marks the final word of a packet.
- REQ0_READY / REQ1_READY  out  1  word accepted this cycle when VALID and READY are both high.
- SER_RESET  out  1  drives the OSER8 RESET input.
- SER_D  out  8  drives OSER8 D7..D0.
- SER_TX  out  4  drives OSER8 TX3..TX0.
- LINK_UP  out  1  high while in IDLE or DATA.
- GRANT  out  2  one-hot owner of the current packet. 0 when no owner.

## Operation
- The FSM has four states: RST, TRAIN, IDLE and DATA.
- RST:
  - SER_RESET=1, SER_TX=TX_OFF, SER_D=IDLE_WORD.
  - The counter runs for RST_CYCLES cycles, then the FSM moves to TRAIN.
- TRAIN:
  - SER_RESET=0, SER_TX=0, SER_D=TRAIN_PAT.
  - After TRAIN_WORDS cycles the FSM moves to IDLE.
- IDLE:
  - Combinational round-robin pick among the requesters with VALID high. The priority pointer favours the requester that did not own the last completed packet; its reset value favours REQ0.
  - Only the picked requester's READY is high, and that word is accepted.
  - If the accepted word has LAST=0: the FSM moves to DATA, the owner is latched and GRANT is set.
  - If the accepted word has LAST=1: the FSM stays in IDLE and the pointer flips.
  - If no word is accepted: SER_D=IDLE_WORD on the next cycle.
- DATA:
  - READY is high only for the owner. The other requester's READY is 0, even if its VALID is high.
  - An owner bubble (VALID=0) emits IDLE_WORD. Bubble-free packets are the sender's responsibility.
  - Accepting a word with LAST=1 returns the FSM to IDLE, clears GRANT and flips the pointer.
- RETRAIN:
  - In IDLE: the FSM enters TRAIN next cycle, with no word accepted that cycle and READY low.
  - In DATA: the request is latched as pending. It is honoured on the cycle after LAST is accepted, before any new grant. Packets are never truncated.
  - In TRAIN: ignored. The counter does not restart.
  - In RST: ignored.
- A single counter of width $clog2(max(RST_CYCLES,TRAIN_WORDS)+1) is shared between RST and TRAIN. It reloads on each state entry and does not wrap.

## Timing
- Every output except READY is registered.
- READY is combinational from state and the VALID inputs.
- A word accepted at PCLK edge N appears on SER_D after edge N+1, so latency is 1 cycle.
- Back-to-back packets run without a gap: a LAST beat in DATA followed by an acceptance in IDLE on the next cycle gives contiguous SER_D words.
- RESET is synchronous and high for one or more cycles. On the first edge after it is sampled high, these values hold until RESET is released:
  - FSM=RST, SER_RESET=1, SER_TX=TX_OFF, SER_D=IDLE_WORD;
  - LINK_UP=0, GRANT=0, READY=0;
  - pointer favours REQ0, pending retrain cleared.
- After RESET is released:
  - SER_RESET stays high for exactly RST_CYCLES more edges;
  - then TRAIN_PAT appears for exactly TRAIN_WORDS cycles;
  - LINK_UP rises in the same cycle as the first post-training SER_D word.
- RESET during DATA aborts the packet immediately, with no further READY. The pending retrain is discarded.
- LINK_UP falls in the cycle SER_D first shows TRAIN_PAT after a retrain.

## Test plan
- Power-up with defaults, RESET held 3 cycles then released:
  - SER_RESET=1 for 8 cycles, SER_TX=F during reset;
  - then 16 words of 8'h6A with SER_TX=0;
  - then 8'h00 with LINK_UP=1.
- Single packet on REQ1 only, 3 words A1, A2, A3 (LAST on A3):
  - GRANT=2'b10 from the cycle after A1 is accepted;
  - SER_D shows A1, A2, A3 on consecutive cycles, 1 cycle after each acceptance;
  - then 00 and GRANT=0.
- Both VALID high continuously, 2-word packets each:
  - order is REQ0, REQ1, REQ0, REQ1;
  - the losing requester's READY stays 0 throughout the winner's packet;
  - there is no idle word between packets.
- RETRAIN pulsed mid-packet on REQ0:
  - the packet completes intact;
  - the next cycle enters TRAIN with LINK_UP=0 and 16 × 6A;
  - no grant is issued until IDLE.
- Owner bubble: REQ0 VALID drops for 2 cycles mid-packet while REQ1 is VALID:
  - SER_D shows 00, 00;
  - REQ1_READY stays 0 and GRANT stays 2'b01.
- RESET asserted in the middle of a REQ1 packet:
  - the next cycle shows SER_RESET=1, GRANT=0 and both READY=0;
  - the full RST then TRAIN sequence repeats, and the first grant after it goes to REQ0.
